dcache_dm: RTL and testbench

//   Direct-mapped, write-back, write-allocate data cache. CPU-side responder for the MEM-stage
//   mem_r_d/mem_w_d request; returns mem_resp_d. Memory side issues 256-bit line bursts to the

---
 rtl/dcache_dm.sv | 127 ++++++++++++
 tb/tb_dcache_dm.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dcache_dm.sv
// dcache_dm: direct-mapped write-back write-allocate data cache between the MEM stage and the memory arbiter
module dcache_dm #(
    parameter int S_INDEX  = 3,
    parameter int S_OFFSET = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read_d,
    input  logic         mem_write_d,
    input  logic [31:0]  mem_address_d,
    input  logic [31:0]  mem_wdata_d,
    input  logic [3:0]   mem_byte_en_d,
    output logic [31:0]  mem_rdata_d,
    output logic         mem_resp_d,
    output logic [31:0]  pmem_address,
    input  logic [255:0] pmem_rdata,
    output logic [255:0] pmem_wdata,
    output logic         pmem_read,
    output logic         pmem_write,
    input  logic         pmem_resp
);
    localparam int NUM_SETS = 2 ** S_INDEX;
    localparam int TAG_W    = 32 - S_INDEX - S_OFFSET;
    localparam logic [1:0] CHECK     = 2'd0;
    localparam logic [1:0] WRITEBACK = 2'd1;
    localparam logic [1:0] FILL      = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [NUM_SETS-1:0] valid_q, valid_d, dirty_q, dirty_d;
    logic [TAG_W-1:0]    tag_q [NUM_SETS];
    logic [TAG_W-1:0]    tag_d [NUM_SETS];
    logic [255:0]        data_q [NUM_SETS];
    logic [255:0]        data_d [NUM_SETS];
    logic [31-S_OFFSET:0] miss_q, miss_d;
    logic [TAG_W-1:0]    tag, miss_tag;
    logic [S_INDEX-1:0]  index, miss_idx;
    logic [2:0]          word;
    logic [255:0]        line, merged;
    logic                hit, req;
    logic                unused_addr_bits;

    assign tag      = mem_address_d[31:S_INDEX+S_OFFSET];
    assign index    = mem_address_d[S_INDEX+S_OFFSET-1:S_OFFSET];
    assign word     = mem_address_d[4:2];
    assign miss_tag = miss_q[31-S_OFFSET:S_INDEX];
    assign miss_idx = miss_q[S_INDEX-1:0];
    assign line     = data_q[index];
    assign hit      = valid_q[index] && (tag_q[index] == tag);
    assign req      = mem_read_d || mem_write_d;
    assign unused_addr_bits = ^mem_address_d[1:0];

    // byte-enable merge of the write data into the addressed word of the resident line
    always_comb begin
        merged = line;
        for (int b = 0; b < 4; b++)
            if (mem_byte_en_d[b]) merged[{word, 2'(b), 3'b000} +: 8] = mem_wdata_d[8*b +: 8];
    end

    // controller: hit service in CHECK, dirty-line writeback, then line fill at the latched miss address
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        tag_d        = tag_q;
        data_d       = data_q;
        miss_d       = miss_q;
        mem_resp_d   = 1'b0;
        mem_rdata_d  = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        if (state_q == CHECK) begin
            if (req && hit) begin
                mem_resp_d  = 1'b1;
                mem_rdata_d = line[{word, 5'b00000} +: 32];
                if (mem_write_d) begin
                    data_d[index]  = merged;
                    dirty_d[index] = 1'b1;
                end
            end else if (req) begin
                miss_d  = mem_address_d[31:S_OFFSET];
                state_d = dirty_q[index] ? WRITEBACK : FILL;
            end
        end else if (state_q == WRITEBACK) begin
            pmem_write   = 1'b1;
            pmem_address = {tag_q[miss_idx], miss_idx, {S_OFFSET{1'b0}}};
            pmem_wdata   = data_q[miss_idx];
            if (pmem_resp) begin
                dirty_d[miss_idx] = 1'b0;
                state_d           = FILL;
            end
        end else if (state_q == FILL) begin
            pmem_read    = 1'b1;
            pmem_address = {miss_q, {S_OFFSET{1'b0}}};
            if (pmem_resp) begin
                data_d[miss_idx]  = pmem_rdata;
                tag_d[miss_idx]   = miss_tag;
                valid_d[miss_idx] = 1'b1;
                dirty_d[miss_idx] = 1'b0;
                state_d           = CHECK;
            end
        end else begin
            state_d = CHECK;
        end
    end

    // control state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CHECK;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // storage arrays and miss address are left unreset; valid bits guard them
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
        miss_q <= miss_d;
    end
endmodule

// File: tb/tb_dcache_dm.sv
// tb_dcache_dm: directed vector bench for the direct-mapped data cache
module tb_dcache_dm;
    logic         clk = 1'b0;
    logic         rst;
    logic         mem_read_d, mem_write_d;
    logic [31:0]  mem_address_d, mem_wdata_d;
    logic [3:0]   mem_byte_en_d;
    logic [31:0]  mem_rdata_d;
    logic         mem_resp_d;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_rdata, pmem_wdata;
    logic         pmem_read, pmem_write, pmem_resp;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        resp;
        logic        chkd;
        logic [31:0] rdata;
    } vec_t;
    vec_t vt [13];

    logic [255:0] line1, line1m, line2, line3;

    dcache_dm dut (
        .clk(clk), .rst(rst),
        .mem_read_d(mem_read_d), .mem_write_d(mem_write_d),
        .mem_address_d(mem_address_d), .mem_wdata_d(mem_wdata_d),
        .mem_byte_en_d(mem_byte_en_d), .mem_rdata_d(mem_rdata_d),
        .mem_resp_d(mem_resp_d), .pmem_address(pmem_address),
        .pmem_rdata(pmem_rdata), .pmem_wdata(pmem_wdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic mem_cycle(input string nm, input bit is_wr, input logic [31:0] addr, input logic [255:0] d);
        int i = 0;
        @(negedge clk); #1;
        while (!(pmem_read || pmem_write) && i < 8) begin
            @(negedge clk); #1;
            i++;
        end
        chk({nm, " busy"}, 256'(pmem_read | pmem_write), 256'd1);
        chk({nm, " both"}, 256'(pmem_read & pmem_write), 256'd0);
        chk({nm, " kind"}, 256'(pmem_write), 256'(is_wr));
        chk({nm, " addr"}, 256'(pmem_address), 256'(addr));
        if (is_wr) chk({nm, " wdata"}, pmem_wdata, d);
        else pmem_rdata = d;
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; mem_read_d = 1'b0; mem_write_d = 1'b0; mem_address_d = '0;
        mem_wdata_d = '0; mem_byte_en_d = '0; pmem_rdata = '0; pmem_resp = 1'b0;
        for (int i = 0; i < 8; i++) begin
            line1[32*i +: 32] = 32'hA000_0000 + 32'(i);
            line2[32*i +: 32] = 32'hB000_0000 + 32'(i);
            line3[32*i +: 32] = 32'hC000_0000 + 32'(i);
        end
        line1[31:0] = 32'hDEAD_BEEF;
        line1m = line1;
        line1m[63:32] = 32'hA000_3344;
        for (int i = 0; i < 8; i++)
            vt[i] = '{rd:1'b1, wr:1'b0, addr:32'h140 + 32'(4*i), wdata:32'h0, be:4'h0,
                      resp:1'b1, chkd:1'b1, rdata:32'hB000_0000 + 32'(i)};
        vt[8]  = '{rd:1'b1, wr:1'b1, addr:32'h148, wdata:32'hCAFE_F00D, be:4'hF, resp:1'b1, chkd:1'b1, rdata:32'hB000_0002};
        vt[9]  = '{rd:1'b1, wr:1'b0, addr:32'h148, wdata:32'h0, be:4'h0, resp:1'b1, chkd:1'b1, rdata:32'hCAFE_F00D};
        vt[10] = '{rd:1'b0, wr:1'b1, addr:32'h14C, wdata:32'h7766_5544, be:4'h8, resp:1'b1, chkd:1'b0, rdata:32'h0};
        vt[11] = '{rd:1'b1, wr:1'b0, addr:32'h14C, wdata:32'h0, be:4'h0, resp:1'b1, chkd:1'b1, rdata:32'h7700_0003};
        vt[12] = '{rd:1'b0, wr:1'b0, addr:32'h140, wdata:32'h0, be:4'h0, resp:1'b0, chkd:1'b1, rdata:32'h0};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset resp", 256'(mem_resp_d), 256'd0);
        chk("reset pmem_read", 256'(pmem_read), 256'd0);
        chk("reset pmem_write", 256'(pmem_write), 256'd0);
        chk("reset rdata", 256'(mem_rdata_d), 256'd0);

        mem_read_d = 1'b1; mem_address_d = 32'h40;
        #1 chk("t1 miss resp", 256'(mem_resp_d), 256'd0);
        mem_cycle("t1 fill", 1'b0, 32'h40, line1);
        #1;
        chk("t1 resp", 256'(mem_resp_d), 256'd1);
        chk("t1 rdata", 256'(mem_rdata_d), 256'hDEAD_BEEF);
        mem_read_d = 1'b0;

        @(negedge clk);
        mem_write_d = 1'b1; mem_address_d = 32'h44; mem_wdata_d = 32'h1122_3344; mem_byte_en_d = 4'b0011;
        #1 chk("t2 write resp", 256'(mem_resp_d), 256'd1);
        @(negedge clk);
        mem_write_d = 1'b0; mem_read_d = 1'b1;
        #1;
        chk("t2 read resp", 256'(mem_resp_d), 256'd1);
        chk("t2 merged", 256'(mem_rdata_d), 256'hA000_3344);

        @(negedge clk);
        mem_address_d = 32'h140;
        #1 chk("t3 miss resp", 256'(mem_resp_d), 256'd0);
        mem_cycle("t3 wb", 1'b1, 32'h40, line1m);
        mem_cycle("t3 fill", 1'b0, 32'h140, line2);
        #1;
        chk("t3 resp", 256'(mem_resp_d), 256'd1);
        chk("t3 rdata", 256'(mem_rdata_d), 256'hB000_0000);
        mem_read_d = 1'b0;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            mem_read_d = vt[i].rd; mem_write_d = vt[i].wr; mem_address_d = vt[i].addr;
            mem_wdata_d = vt[i].wdata; mem_byte_en_d = vt[i].be;
            #1;
            chk($sformatf("t4 v%0d resp", i), 256'(mem_resp_d), 256'(vt[i].resp));
            if (vt[i].chkd) chk($sformatf("t4 v%0d rdata", i), 256'(mem_rdata_d), 256'(vt[i].rdata));
            chk($sformatf("t4 v%0d pmem", i), 256'(pmem_read | pmem_write), 256'd0);
        end

        @(negedge clk);
        mem_read_d = 1'b1; mem_address_d = 32'h60;
        #1 chk("t5 miss resp", 256'(mem_resp_d), 256'd0);
        @(negedge clk); #1;
        chk("t5 fill read", 256'(pmem_read), 256'd1);
        chk("t5 fill addr", 256'(pmem_address), 256'h60);
        rst = 1'b1; mem_read_d = 1'b0;
        @(negedge clk); #1;
        rst = 1'b0;
        chk("t5 rst pmem_read", 256'(pmem_read), 256'd0);
        chk("t5 rst pmem_write", 256'(pmem_write), 256'd0);
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        #1 chk("t5 late resp ignored", 256'(pmem_read | pmem_write | mem_resp_d), 256'd0);
        mem_read_d = 1'b1; mem_address_d = 32'h140;
        #1 chk("t5 now misses", 256'(mem_resp_d), 256'd0);
        mem_cycle("t5 refill", 1'b0, 32'h140, line2);
        #1;
        chk("t5 resp", 256'(mem_resp_d), 256'd1);
        chk("t5 rdata", 256'(mem_rdata_d), 256'hB000_0000);
        mem_read_d = 1'b0;

        @(negedge clk);
        mem_read_d = 1'b1; mem_address_d = 32'h80;
        #1 chk("t6 miss resp", 256'(mem_resp_d), 256'd0);
        @(negedge clk); #1;
        chk("t6 fill read", 256'(pmem_read), 256'd1);
        chk("t6 fill addr", 256'(pmem_address), 256'h80);
        mem_read_d = 1'b0; pmem_rdata = line3; pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        #1;
        chk("t6 no resp", 256'(mem_resp_d), 256'd0);
        chk("t6 idle", 256'(pmem_read | pmem_write), 256'd0);
        @(negedge clk);
        mem_read_d = 1'b1; mem_address_d = 32'h84;
        #1;
        chk("t6 hit resp", 256'(mem_resp_d), 256'd1);
        chk("t6 hit rdata", 256'(mem_rdata_d), 256'hC000_0001);
        chk("t6 hit no pmem", 256'(pmem_read), 256'd0);
        @(negedge clk); #1;
        chk("t6 held resp", 256'(mem_resp_d), 256'd1);
        chk("t6 held rdata", 256'(mem_rdata_d), 256'hC000_0001);
        mem_read_d = 1'b0;
        @(negedge clk); #1;
        chk("t6 idle resp", 256'(mem_resp_d), 256'd0);
        chk("t6 idle rdata", 256'(mem_rdata_d), 256'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
